// File: rtl/imm_gen_pipe_if.sv
// Handshake and result bundle between the ID-stage instruction feed and the
// immediate generator. The slave side is the generator itself.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] imm_o;
  logic [2:0]      imm_type_o;
  logic            is_compressed_o;
  logic            illegal_o;
  logic [31:0]     instr_o;

  modport slave (
    input  in_valid_i, instr_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, imm_type_o, is_compressed_o, illegal_o, instr_o
  );

  modport master (
    output in_valid_i, instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, imm_type_o, is_compressed_o, illegal_o, instr_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32/RV64 immediate generator with optional RVC decode, a one-entry
// output register with backpressure, and flush.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter bit C_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  imm_gen_pipe_if.slave bus
);

  localparam bit IS64 = (XLEN == 64);

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;
  localparam logic [2:0] T_CI    = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      ty;
    logic            comp;
    logic            ill;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [5:0] ci6;
    logic [9:0] nz10;
    d.imm  = {XLEN{1'b0}};
    d.ty   = T_NONE;
    d.ill  = 1'b0;
    d.comp = C_EN && (ins[1:0] != 2'b11);
    ci6    = {ins[12], ins[6:2]};
    if (!d.comp) begin
      case (ins[6:0])
        7'b0000011, 7'b1100111: begin
          d.imm = XLEN'($signed(ins[31:20]));
          d.ty  = T_I;
        end
        7'b0010011: begin
          // funct3 001/101 are the shift-immediate forms
          if (ins[13:12] == 2'b01) begin
            d.imm = IS64 ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
            d.ty  = T_SHAMT;
          end else begin
            d.imm = XLEN'($signed(ins[31:20]));
            d.ty  = T_I;
          end
        end
        7'b0011011: begin
          if (IS64) begin
            d.imm = XLEN'($signed(ins[31:20]));
            d.ty  = T_I;
          end else begin
            d.ty  = T_NONE;
          end
        end
        7'b0100011: begin
          d.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
          d.ty  = T_S;
        end
        7'b1100011: begin
          d.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
          d.ty  = T_B;
        end
        7'b0110111, 7'b0010111: begin
          d.imm = XLEN'($signed({ins[31:12], 12'h000}));
          d.ty  = T_U;
        end
        7'b1101111: begin
          d.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
          d.ty  = T_J;
        end
        default: d.ty = T_NONE;
      endcase
    end else if (ins[15:0] == 16'h0000) begin
      d.ill = 1'b1;
    end else begin
      case ({ins[15:13], ins[1:0]})
        5'b000_00: begin
          d.imm = XLEN'({ins[10:7], ins[12:11], ins[5], ins[6], 2'b00});
          d.ty  = T_CI;
          d.ill = (ins[12:5] == 8'h00);
        end
        5'b010_00, 5'b110_00: begin
          d.imm = XLEN'({ins[5], ins[12:10], ins[6], 2'b00});
          d.ty  = ins[15] ? T_S : T_CI;
        end
        5'b000_01, 5'b010_01: begin
          d.imm = XLEN'($signed(ci6));
          d.ty  = T_CI;
        end
        5'b001_01: begin
          // RV32 C.JAL, RV64 C.ADDIW
          if (IS64) begin
            d.imm = XLEN'($signed(ci6));
            d.ty  = T_CI;
          end else begin
            d.imm = XLEN'($signed({ins[12], ins[8], ins[10:9], ins[6], ins[7], ins[2], ins[11], ins[5:3], 1'b0}));
            d.ty  = T_J;
          end
        end
        5'b011_01: begin
          if (ins[11:7] == 5'd2) begin
            nz10  = {ins[12], ins[4:3], ins[5], ins[2], ins[6], 4'h0};
            d.imm = XLEN'($signed(nz10));
            d.ty  = T_CI;
          end else begin
            d.imm = XLEN'($signed({ci6, 12'h000}));
            d.ty  = T_U;
          end
          d.ill = (ci6 == 6'h00);
        end
        5'b100_01: begin
          case (ins[11:10])
            2'b00, 2'b01: begin
              d.imm = XLEN'(ci6);
              d.ty  = T_SHAMT;
              d.ill = !IS64 && ins[12];
            end
            2'b10: begin
              d.imm = XLEN'($signed(ci6));
              d.ty  = T_CI;
            end
            default: d.ty = T_NONE;
          endcase
        end
        5'b101_01: begin
          d.imm = XLEN'($signed({ins[12], ins[8], ins[10:9], ins[6], ins[7], ins[2], ins[11], ins[5:3], 1'b0}));
          d.ty  = T_J;
        end
        5'b110_01, 5'b111_01: begin
          d.imm = XLEN'($signed({ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0}));
          d.ty  = T_B;
        end
        5'b000_10: begin
          d.imm = XLEN'(ci6);
          d.ty  = T_SHAMT;
          d.ill = !IS64 && ins[12];
        end
        5'b010_10: begin
          d.imm = XLEN'({ins[3:2], ins[12], ins[6:4], 2'b00});
          d.ty  = T_CI;
        end
        5'b110_10: begin
          d.imm = XLEN'({ins[8:7], ins[12:9], 2'b00});
          d.ty  = T_S;
        end
        default: d.ty = T_NONE;
      endcase
    end
    return d;
  endfunction

  logic            valid_q, valid_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [2:0]      type_q, type_d;
  logic            comp_q, comp_d;
  logic            ill_q, ill_d;
  logic [31:0]     instr_q, instr_d;
  logic            accept_s;
  dec_t            dec_s;

  assign bus.in_ready_o = !valid_q || bus.out_ready_i;
  assign accept_s       = bus.in_valid_i && bus.in_ready_o && !flush_i;

  // Combinational decode of the incoming instruction.
  always_comb begin
    dec_s = decode(bus.instr_i);
  end

  // Next state of the output register: flush, then load, then drain, else hold.
  always_comb begin
    valid_d = valid_q;
    imm_d   = imm_q;
    type_d  = type_q;
    comp_d  = comp_q;
    ill_d   = ill_q;
    instr_d = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      imm_d   = dec_s.imm;
      type_d  = dec_s.ty;
      comp_d  = dec_s.comp;
      ill_d   = dec_s.ill;
      instr_d = bus.instr_i;
    end else if (bus.out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      imm_q   <= {XLEN{1'b0}};
      type_q  <= T_NONE;
      comp_q  <= 1'b0;
      ill_q   <= 1'b0;
      instr_q <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
      type_q  <= type_d;
      comp_q  <= comp_d;
      ill_q   <= ill_d;
      instr_q <= instr_d;
    end
  end

  assign bus.out_valid_o     = valid_q;
  assign bus.imm_o           = imm_q;
  assign bus.imm_type_o      = type_q;
  assign bus.is_compressed_o = comp_q;
  assign bus.illegal_o       = ill_q;
  assign bus.instr_o         = instr_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: one RV32 and one RV64 instance fed the same stream,
// compared every cycle against an arithmetic model of the immediate rules.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .C_EN(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(bus32.slave)
  );
  imm_gen_pipe #(.XLEN(64), .C_EN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(bus64.slave)
  );

  // expected state after the most recent edge; index 0 = RV32, 1 = RV64
  bit          e_valid;
  bit          e_known;
  logic [63:0] e_imm   [2];
  logic [2:0]  e_ty    [2];
  logic        e_comp  [2];
  logic        e_ill   [2];
  logic [31:0] e_instr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint unsigned fld(input logic [31:0] i, input int hi, input int lo);
    longint unsigned v;
    v = 64'(i) >> lo;
    return v & ((64'd1 << (hi - lo + 1)) - 64'd1);
  endfunction

  function automatic longint sx(input longint unsigned v, input int b);
    longint unsigned m;
    m = 64'd1 << (b - 1);
    return longint'((v ^ m) - m);
  endfunction

  function automatic void ref_dec(input logic [31:0] ins, input bit x64, output logic [63:0] imm,
                                  output logic [2:0] ty, output logic comp, output logic ill);
    longint v;
    longint unsigned n;
    int key;
    v = 0; ty = 3'd0; ill = 1'b0;
    comp = (ins[1:0] != 2'b11);
    if (!comp) begin
      case (ins[6:0])
        7'h03, 7'h67: begin v = sx(fld(ins,31,20),12); ty = 3'd1; end
        7'h13: if (fld(ins,14,12) == 1 || fld(ins,14,12) == 5) begin
                 v = x64 ? fld(ins,25,20) : fld(ins,24,20); ty = 3'd6;
               end else begin v = sx(fld(ins,31,20),12); ty = 3'd1; end
        7'h1B: if (x64) begin v = sx(fld(ins,31,20),12); ty = 3'd1; end
        7'h23: begin v = sx(fld(ins,31,25)*32 + fld(ins,11,7),12); ty = 3'd2; end
        7'h63: begin v = sx(fld(ins,31,31)*4096 + fld(ins,7,7)*2048 + fld(ins,30,25)*32 + fld(ins,11,8)*2,13); ty = 3'd3; end
        7'h37, 7'h17: begin v = sx(fld(ins,31,12),20)*4096; ty = 3'd4; end
        7'h6F: begin v = sx(fld(ins,31,31)*(1<<20) + fld(ins,19,12)*4096 + fld(ins,20,20)*2048 + fld(ins,30,21)*2,21); ty = 3'd5; end
        default: ;
      endcase
    end else if (ins[15:0] == 16'h0) begin
      ill = 1'b1;
    end else begin
      key = int'(fld(ins,15,13))*4 + int'(fld(ins,1,0));
      n   = fld(ins,12,12)*32 + fld(ins,6,2);
      case (key)
        0: begin v = fld(ins,12,11)*16 + fld(ins,10,7)*64 + fld(ins,6,6)*4 + fld(ins,5,5)*8; ty = 3'd7; ill = (v == 0); end
        8: begin v = fld(ins,12,10)*8 + fld(ins,6,6)*4 + fld(ins,5,5)*64; ty = 3'd7; end
        24: begin v = fld(ins,12,10)*8 + fld(ins,6,6)*4 + fld(ins,5,5)*64; ty = 3'd2; end
        1, 9: begin v = sx(n,6); ty = 3'd7; end
        5, 21: if (key == 5 && x64) begin v = sx(n,6); ty = 3'd7; end
               else begin
                 v = sx(fld(ins,12,12)*2048 + fld(ins,11,11)*16 + fld(ins,10,9)*256 + fld(ins,8,8)*1024
                        + fld(ins,7,7)*64 + fld(ins,6,6)*128 + fld(ins,5,3)*2 + fld(ins,2,2)*32, 12);
                 ty = 3'd5;
               end
        13: if (fld(ins,11,7) == 2) begin
              v = sx(fld(ins,12,12)*512 + fld(ins,6,6)*16 + fld(ins,5,5)*64 + fld(ins,4,3)*128 + fld(ins,2,2)*32,10);
              ty = 3'd7; ill = (v == 0);
            end else begin v = sx(n,6)*4096; ty = 3'd4; ill = (n == 0); end
        17: case (fld(ins,11,10))
              0, 1: begin v = n; ty = 3'd6; ill = !x64 && ins[12]; end
              2: begin v = sx(n,6); ty = 3'd7; end
              default: ;
            endcase
        25, 29: begin v = sx(fld(ins,12,12)*256 + fld(ins,11,10)*8 + fld(ins,6,5)*64 + fld(ins,4,3)*2 + fld(ins,2,2)*32,9); ty = 3'd3; end
        2: begin v = n; ty = 3'd6; ill = !x64 && ins[12]; end
        10: begin v = fld(ins,12,12)*32 + fld(ins,6,4)*4 + fld(ins,3,2)*64; ty = 3'd7; end
        26: begin v = fld(ins,12,9)*4 + fld(ins,8,7)*64; ty = 3'd2; end
        default: ;
      endcase
    end
    imm = 64'(v);
    if (!x64) imm = imm & 64'h0000_0000_FFFF_FFFF;
  endfunction

  // compare all DUT outputs against the model state
  task automatic compare();
    chk("valid32", 64'(bus32.out_valid_o), 64'(e_valid));
    chk("valid64", 64'(bus64.out_valid_o), 64'(e_valid));
    if (e_known) begin
      chk("imm32", {32'h0, bus32.imm_o}, e_imm[0]);
      chk("type32", 64'(bus32.imm_type_o), 64'(e_ty[0]));
      chk("comp32", 64'(bus32.is_compressed_o), 64'(e_comp[0]));
      chk("ill32", 64'(bus32.illegal_o), 64'(e_ill[0]));
      chk("instr32", 64'(bus32.instr_o), 64'(e_instr));
      chk("imm64", bus64.imm_o, e_imm[1]);
      chk("type64", 64'(bus64.imm_type_o), 64'(e_ty[1]));
      chk("comp64", 64'(bus64.is_compressed_o), 64'(e_comp[1]));
      chk("ill64", 64'(bus64.illegal_o), 64'(e_ill[1]));
      chk("instr64", 64'(bus64.instr_o), 64'(e_instr));
    end
  endtask

  task automatic set_zero();
    e_valid = 1'b0; e_known = 1'b1; e_instr = 32'h0;
    for (int k = 0; k < 2; k++) begin
      e_imm[k] = 64'h0; e_ty[k] = 3'd0; e_comp[k] = 1'b0; e_ill[k] = 1'b0;
    end
  endtask

  // one clock: drive, check ready, advance model, check outputs after the edge
  task automatic step(input bit r, input bit fl, input bit v, input logic [31:0] ins, input bit rdy);
    bit exp_rdy, acc;
    rst_n = r; flush = fl;
    bus32.in_valid_i = v; bus32.instr_i = ins; bus32.out_ready_i = rdy;
    bus64.in_valid_i = v; bus64.instr_i = ins; bus64.out_ready_i = rdy;
    #1;
    exp_rdy = !e_valid || rdy;
    chk("in_ready32", 64'(bus32.in_ready_o), 64'(exp_rdy));
    chk("in_ready64", 64'(bus64.in_ready_o), 64'(exp_rdy));
    acc = v && exp_rdy && !fl;
    if (!r) set_zero();
    else if (fl) begin e_valid = 1'b0; e_known = 1'b0; end
    else if (acc) begin
      e_valid = 1'b1; e_known = 1'b1; e_instr = ins;
      ref_dec(ins, 1'b0, e_imm[0], e_ty[0], e_comp[0], e_ill[0]);
      ref_dec(ins, 1'b1, e_imm[1], e_ty[1], e_comp[1], e_ill[1]);
    end else if (rdy) e_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  logic [6:0] ops [10] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    logic [63:0] mi;
    logic [2:0]  mt;
    logic        mc, ml;
    logic [31:0] ins;

    // hand-computed values pinning the model
    ref_dec(32'hFFC12083, 1'b0, mi, mt, mc, ml);
    chk("model_lw_imm", mi, 64'hFFFF_FFFC); chk("model_lw_type", 64'(mt), 64'd1);
    ref_dec(32'hFE000CE3, 1'b0, mi, mt, mc, ml);
    chk("model_beq_imm", mi, 64'hFFFF_FFF8); chk("model_beq_type", 64'(mt), 64'd3);
    ref_dec(32'h123450B7, 1'b1, mi, mt, mc, ml);
    chk("model_lui64_imm", mi, 64'h0000_0000_1234_5000);
    ref_dec(32'h000050FD, 1'b0, mi, mt, mc, ml);
    chk("model_cli_imm", mi, 64'hFFFF_FFFF); chk("model_cli_type", 64'(mt), 64'd7);
    ref_dec(32'h03F0D013, 1'b1, mi, mt, mc, ml);
    chk("model_srli64", mi, 64'h3F);
    ref_dec(32'h03F0D013, 1'b0, mi, mt, mc, ml);
    chk("model_srli32", mi, 64'h1F);

    rst_n = 1'b0; flush = 1'b0;
    bus32.in_valid_i = 1'b0; bus32.instr_i = 32'h0; bus32.out_ready_i = 1'b0;
    bus64.in_valid_i = 1'b0; bus64.instr_i = 32'h0; bus64.out_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_zero();
    compare();

    // directed sequence
    step(1, 0, 1, 32'hFFC12083, 1);
    chk("lw_dut_imm", 64'(bus32.imm_o), 64'hFFFF_FFFC);
    step(1, 0, 1, 32'hFE000CE3, 1);
    chk("beq_dut_imm", 64'(bus32.imm_o), 64'hFFFF_FFF8);
    for (int k = 0; k < 3; k++) step(1, 0, 1, 32'h123450B7, 0);
    chk("stall_hold_imm", 64'(bus32.imm_o), 64'hFFFF_FFF8);
    step(1, 0, 1, 32'h123450B7, 1);
    chk("lui_dut_imm", 64'(bus32.imm_o), 64'h1234_5000);
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 1, 32'h000050FD, 1);
    chk("cli_dut_imm", 64'(bus32.imm_o), 64'hFFFF_FFFF);
    step(1, 1, 1, 32'h0000_0000, 1);
    step(1, 0, 1, 32'h0000_0000, 1);
    chk("c0_dut_ill", 64'(bus32.illegal_o), 64'd1);
    step(1, 0, 1, 32'h03F0D013, 0);
    step(0, 0, 1, 32'h03F0D013, 0);
    step(1, 0, 1, 32'h03F0D013, 1);
    chk("srli64_dut", bus64.imm_o, 64'h3F);
    chk("srli32_dut", 64'(bus32.imm_o), 64'h1F);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      ins = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        ins[1:0] = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 30) == 0) ins[15:0] = 16'h0;
      end else begin
        ins[6:0] = ops[$urandom_range(0, 9)];
      end
      step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7, ins, $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
